// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit direction counters, mispredict detection and saturating stats
module branch_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [XLEN-1:0]  if_pc,
  output logic             pred_taken,
  output logic [XLEN-1:0]  pred_target,
  input  logic             upd_valid,
  input  logic             upd_is_jump,
  input  logic [XLEN-1:0]  upd_pc,
  input  logic             upd_taken,
  input  logic [XLEN-1:0]  upd_target,
  input  logic             upd_pred_taken,
  input  logic [XLEN-1:0]  upd_pred_target,
  output logic             mispredict,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispredicts
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic             valid_q [ENTRIES];
  logic             jump_q  [ENTRIES];
  logic [1:0]       ctr_q   [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [XLEN-1:0]  tgt_q   [ENTRIES];

  logic [IDX_W-1:0] if_idx, up_idx;
  logic [TAG_W-1:0] if_tag, up_tag;
  logic             if_hit, up_hit;

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[XLEN-1:IDX_W+2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[XLEN-1:IDX_W+2];
  assign if_hit = valid_q[if_idx] && tag_q[if_idx] == if_tag;
  assign up_hit = valid_q[up_idx] && tag_q[up_idx] == up_tag;

  // Lookup reads registered state only, so a same-cycle update is seen next cycle.
  assign pred_taken  = !rst && if_hit && (jump_q[if_idx] || ctr_q[if_idx][1]);
  assign pred_target = pred_taken ? tgt_q[if_idx] : if_pc + XLEN'(4);
  assign mispredict  = upd_valid && (upd_taken != upd_pred_taken || (upd_taken && upd_pred_target != upd_target));
  assign redirect_pc = upd_taken ? upd_target : upd_pc + XLEN'(4);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        jump_q[i]  <= 1'b0;
        ctr_q[i]   <= 2'd0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
      end
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (upd_valid && !clear) begin
        if (up_hit) begin
          if (upd_is_jump) begin
            tgt_q[up_idx] <= upd_target;
            ctr_q[up_idx] <= 2'd3;
          end else if (upd_taken) begin
            tgt_q[up_idx] <= upd_target;
            ctr_q[up_idx] <= ctr_q[up_idx] == 2'd3 ? 2'd3 : ctr_q[up_idx] + 2'd1;
          end else begin
            ctr_q[up_idx] <= ctr_q[up_idx] == 2'd0 ? 2'd0 : ctr_q[up_idx] - 2'd1;
          end
        end else if (upd_taken) begin
          valid_q[up_idx] <= 1'b1;
          tag_q[up_idx]   <= up_tag;
          tgt_q[up_idx]   <= upd_target;
          jump_q[up_idx]  <= upd_is_jump;
          ctr_q[up_idx]   <= upd_is_jump ? 2'd3 : 2'd2;
        end
      end
      if (clear)
        for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
      if (upd_valid && stat_branches != '1)
        stat_branches <= stat_branches + CNT_W'(1);
      if (mispredict && stat_mispredicts != '1)
        stat_mispredicts <= stat_mispredicts + CNT_W'(1);
    end
  end
endmodule
